// File: rtl/moore_sequence_generator_pkg.sv
// Shared definitions for the Moore sequence generator and its detector:
// FSM state encoding, default pattern width and the detector's target pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int SEQ_PAT_W = 4;

  // Pattern the downstream Moore detector looks for; both sides share it.
  localparam logic [3:0] SEQ_TARGET_PATTERN = 4'b1011;

endpackage : seq_pkg

// File: rtl/moore_sequence_generator_if.sv
// Request/serial-output bundle of the sequence generator. The master side
// issues transmissions; the slave side (the generator) drives the stream.
interface moore_sequence_generator_if #(
  parameter int PAT_W = seq_pkg::SEQ_PAT_W,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             sequence_out;
  logic             valid_out;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap, abort,
    input  sequence_out, valid_out, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap, abort,
    output sequence_out, valid_out, busy, done
  );

endinterface : moore_sequence_generator_if

// File: rtl/moore_sequence_generator_piso_shift_reg.sv
// Parallel-in, serial-out shift register. Load has priority over shift;
// the serial output is the MSB, so data leaves MSB first.
module piso_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  // Shift register: parallel load or shift left, zero-filling the LSB.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[W-1];

endmodule : piso_shift_reg

// File: rtl/moore_sequence_generator.sv
// Serial pattern transmitter feeding the Moore sequence detector. Captures a
// pattern on start and shifts it out MSB first, optionally repeating it with
// an idle gap between repetitions. Outputs decode registered state only.
module moore_sequence_generator
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  moore_sequence_generator_if.slave    gen
);

  localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  seq_state_e       state_q,   state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q,     pat_d;
  logic [GAP_W-1:0] gap_q,     gap_d;

  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_data;
  logic             sr_msb;

  piso_shift_reg #(.W(PAT_W)) u_piso (
    .clk     (clock),
    .rst_n   (reset_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_data),
    .msb_o   (sr_msb)
  );

  // Next-state, counter and shift-register control decode.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    gap_d     = gap_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = pat_q;

    if (gen.abort && (state_q != IDLE)) begin
      // Cancel: drop back to IDLE with cleared counters and no done pulse.
      state_d   = IDLE;
      bit_cnt_d = '0;
      rep_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gen.start && !gen.abort) begin
            pat_d     = gen.pattern;
            gap_d     = gen.gap;
            rep_cnt_d = gen.repeat_cnt;
            bit_cnt_d = BIT_LAST;
            sr_data   = gen.pattern;
            sr_load   = 1'b1;
            state_d   = SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt_q != '0) begin
            sr_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else if (rep_cnt_q != '0) begin
            if (gap_q == '0) begin
              // Back-to-back repetition: reload without a bubble.
              sr_load   = 1'b1;
              bit_cnt_d = BIT_LAST;
              rep_cnt_d = rep_cnt_q - 1'b1;
            end else begin
              gap_cnt_d = gap_q - 1'b1;
              state_d   = GAP;
            end
          end else begin
            state_d = DONE;
          end
        end

        GAP: begin
          if (gap_cnt_q == '0) begin
            sr_load   = 1'b1;
            bit_cnt_d = BIT_LAST;
            rep_cnt_d = rep_cnt_q - 1'b1;
            state_d   = SHIFT;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and capture registers; reset discards any capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
      gap_q     <= gap_d;
    end
  end

  // Moore output decode: registered state and shift register only.
  assign gen.sequence_out = (state_q == SHIFT) & sr_msb;
  assign gen.valid_out    = (state_q == SHIFT);
  assign gen.busy         = (state_q == SHIFT) | (state_q == GAP);
  assign gen.done         = (state_q == DONE);

endmodule : moore_sequence_generator

// File: tb/tb_moore_sequence_generator.sv
// Scoreboard bench for moore_sequence_generator: the stimulus side pushes the
// expected serial bits into a queue; a negedge monitor pops one per valid bit.
module tb_moore_sequence_generator;
  import seq_pkg::*;

  localparam int PW = 4;
  localparam int CW = 4;
  localparam int GW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  moore_sequence_generator_if #(.PAT_W(PW), .CNT_W(CW), .GAP_W(GW)) bus ();

  moore_sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .gen     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];
  int done_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference stream: every repetition contributes the pattern MSB first;
  // gap cycles carry no valid bits, so they add nothing to the queue.
  task automatic push_model(input logic [PW-1:0] pat, input int reps);
    for (int r = 0; r <= reps; r++)
      for (int i = PW - 1; i >= 0; i--)
        exp_q.push_back(pat[i]);
  endtask

  // Monitor: compare each presented bit against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out) begin
        if (exp_q.size() == 0) check("extra_bit", 32'(bus.valid_out), 32'd0);
        else check("bit", 32'(bus.sequence_out), 32'(exp_q.pop_front()));
      end else if (bus.busy) begin
        check("gap_data", 32'(bus.sequence_out), 32'd0);
      end
      if (bus.done) begin
        check("done_expected", 32'(done_pending != 0), 32'd1);
        if (done_pending > 0) done_pending--;
      end
    end
  end

  // Full transmission: drive at a negedge while IDLE, measure busy, check
  // the done pulse and return at a negedge in IDLE.
  task automatic do_tx(input logic [PW-1:0] pat, input int reps, input int gp, input bit poke);
    int busy_cycles;
    push_model(pat, reps);
    done_pending++;
    bus.pattern    = pat;
    bus.repeat_cnt = CW'(reps);
    bus.gap        = GW'(gp);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.pattern    = PW'($urandom);
    bus.repeat_cnt = CW'($urandom);
    bus.gap        = GW'($urandom);
    busy_cycles = 0;
    while (busy_cycles < 1000) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cycles++;
      bus.start = poke && (busy_cycles == 2);
    end
    bus.start = 1'b0;
    check("busy_len", 32'(busy_cycles), 32'((reps + 1) * PW + reps * gp));
    check("done_pulse", 32'(bus.done), 32'd1);
    if (poke) begin
      bus.start   = 1'b1;
      bus.pattern = PW'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_width", 32'(bus.done), 32'd0);
    check("idle_after", 32'(bus.busy), 32'd0);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_seq"},   32'(bus.sequence_out), 32'd0);
    check({name, "_valid"}, 32'(bus.valid_out),    32'd0);
    check({name, "_busy"},  32'(bus.busy),         32'd0);
    check({name, "_done"},  32'(bus.done),         32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern = '0; bus.repeat_cnt = '0; bus.gap = '0;
    #12;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: single, back-to-back, gapped repetitions.
    do_tx(SEQ_TARGET_PATTERN, 0, 0, 1'b0);
    do_tx(SEQ_TARGET_PATTERN, 1, 0, 1'b1);
    do_tx(SEQ_TARGET_PATTERN, 2, 2, 1'b1);

    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1; bus.abort = 1'b1; bus.pattern = SEQ_TARGET_PATTERN;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check_quiet("start_abort_idle");
    @(negedge clk);
    check_quiet("start_abort_idle2");

    // Abort on the 3rd bit: three bits seen, then IDLE with no done.
    for (int i = PW - 1; i >= PW - 3; i--) exp_q.push_back(SEQ_TARGET_PATTERN[i]);
    bus.pattern = SEQ_TARGET_PATTERN; bus.repeat_cnt = 4'd3; bus.gap = 4'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check_quiet("after_abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    check("abort_drained", 32'(exp_q.size()), 32'd0);

    // Reset on the 2nd bit: outputs clear before the next edge.
    for (int i = PW - 1; i >= PW - 2; i--) exp_q.push_back(SEQ_TARGET_PATTERN[i]);
    bus.pattern = SEQ_TARGET_PATTERN; bus.repeat_cnt = 4'd2; bus.gap = 4'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");
    check("reset_drained", 32'(exp_q.size()), 32'd0);

    // Maximum repeat count: 2^CNT_W transmissions without wrap.
    do_tx(PW'($urandom), (1 << CW) - 1, 1, 1'b0);

    // Randomised transmissions.
    for (int n = 0; n < 25; n++)
      do_tx(PW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
            1'($urandom));

    repeat (3) @(negedge clk);
    check("final_done_pending", 32'(done_pending), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_moore_sequence_generator

// File: doc/moore_sequence_generator.md
# moore_sequence_generator

Serial pattern transmitter that drives the bit stream consumed by the Moore sequence detector. A parallel pattern is captured on a start request and shifted out MSB-first, one bit per clock. The pattern is optionally repeated with a programmable idle gap between repetitions. The block sits on the transmit side of the detector's `sequence_in` line and is the stimulus source for detector loopback tests.

## Interface
Parameters:
- `PAT_W`, 4: pattern length in bits (≥2).
- `CNT_W`, 4: width of the repeat count.
- `GAP_W`, 4: width of the gap length.

Ports:
- `clock` input 1: single clock; everything is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a transmission; sampled only in IDLE.
- `pattern` input PAT_W: bits to send, MSB first; captured on an accepted start.
- `repeat_cnt` input CNT_W: extra repetitions; total transmissions = `repeat_cnt`+1. Captured on an accepted start.
- `gap` input GAP_W: number of idle cycles between repetitions. Captured on an accepted start.
- `abort` input 1: synchronous cancel.
- `sequence_out` output 1: serial data.
- `valid_out` output 1: high when `sequence_out` carries a pattern bit.
- `busy` output 1: high in SHIFT and GAP.
- `done` output 1: one-cycle completion pulse.

## Operation
- The FSM is Moore. All outputs are decoded from registered state and the shift register only; no input reaches an output combinationally.
- IDLE: all outputs 0. When `start` is 1 and `abort` is 0 at an edge:
  - capture `pattern`, `repeat_cnt` and `gap`;
  - load the shift register;
  - set bit counter to PAT_W-1 and repetition counter to `repeat_cnt`;
  - go to SHIFT.
- SHIFT:
  - `sequence_out` = shift register MSB; `valid_out`=1; `busy`=1.
  - Each edge shifts left and decrements the bit counter.
  - On the last bit (counter = 0):
    - repetitions remain and `gap`=0: reload the captured pattern and stay in SHIFT (back-to-back, no bubble);
    - repetitions remain and `gap`>0: go to GAP with gap counter = `gap`-1;
    - no repetitions remain: go to DONE.
  - The repetition counter decrements on each reload.
- GAP: `sequence_out`=0, `valid_out`=0, `busy`=1. When the gap counter reaches 0, reload the pattern and go to SHIFT.
- DONE: `done`=1, `busy`=0, `valid_out`=0. Unconditionally go to IDLE next edge. `start` is ignored in DONE.
- `start` in SHIFT or GAP is ignored; it is not queued.
- `abort`=1 in SHIFT, GAP or DONE: go to IDLE at the next edge. No `done` pulse is produced; counters are cleared.
- `abort` and `start` both high in IDLE: abort wins and nothing is accepted.
- `reset_n` low at any time, including mid-pattern:
  - state goes to IDLE immediately;
  - shift register and counters are cleared;
  - `sequence_out`, `valid_out`, `busy` and `done` are all 0 asynchronously;
  - a captured pattern is discarded.
- Counters are unsigned, use the full parameter widths and never wrap. `repeat_cnt` at its maximum gives 2^CNT_W transmissions.

## Timing
- Start accepted at edge k: first bit is valid in the cycle after edge k. Bit i (MSB = 0) is on `sequence_out` in cycle k+1+i.
- Single transmission: `valid_out` is high for exactly PAT_W cycles, then `done` is high for 1 cycle, then IDLE. The earliest next start is accepted at the edge that leaves DONE+1, i.e. the first IDLE edge.
- With R = `repeat_cnt` and G = `gap`: `busy` duration = (R+1)·PAT_W + R·G cycles.
- Each output bit is stable for a full clock period and changes only on rising edges. The detector samples it safely on the same clock.

## Structure
- Shared package `seq_pkg`:
  - state typedef (IDLE, SHIFT, GAP, DONE) with a 2-bit encoding;
  - default `PAT_W` of 4;
  - named constant for the detector's target pattern 4'b1011, shared with the detector.
- One sub-module, `piso_shift_reg`: a parallel-load, shift-left register of width PAT_W with `load`/`shift` enables and serial MSB output. The FSM, counters and output decode stay in the top module.

## Test plan
- Pattern 4'b1011, `repeat_cnt`=0, `gap`=0 → `sequence_out` 1,0,1,1 with `valid_out`=1 in cycles k+1..k+4; `done`=1 in cycle k+5; IDLE in cycle k+6.
- 4'b1011, `repeat_cnt`=1, `gap`=0 → 8 consecutive valid bits 10111011 with no bubble; a single `done`.
- 4'b1011, `repeat_cnt`=2, `gap`=2 → 1011, 00 (valid=0), 1011, 00, 1011; `busy` high for 16 cycles.
- `start` pulsed during SHIFT and during DONE → ignored; the output stream is unchanged.
- `abort` asserted on the 3rd bit → IDLE next cycle, with no `done`, and all outputs 0. `reset_n` dropped on the 2nd bit → all outputs 0 immediately, before the next edge.
- Loopback into the detector with pattern 4'b1011 → `detector_out` asserts once per transmission.
